// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path and its display-side reader.
//   cam_state_t   : capture FSM encoding
//   RGB_R/G/B     : bit positions inside the 3-bit pixel
//   BLACK/RED/WHITE : colour constants shared with the display side
//   X_W/Y_W       : pixel and line counter widths
package cam_pkg;

    typedef enum logic [1:0] {
        S_WAIT_VS    = 2'd0,
        S_WAIT_START = 2'd1,
        S_CAPTURE    = 2'd2
    } cam_state_t;

    localparam int unsigned RGB_R = 2;
    localparam int unsigned RGB_G = 1;
    localparam int unsigned RGB_B = 0;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    // Reduce RGB565 to 3-bit RGB by keeping the MSB of each channel.
    function automatic logic [2:0] rgb3_from_msbs(input logic r, input logic g, input logic b);
        logic [2:0] v;
        v        = BLACK;
        v[RGB_R] = r;
        v[RGB_G] = g;
        v[RGB_B] = b;
        return v;
    endfunction

endpackage

// File: rtl/camera_capture_rgb565_pack.sv
// Pairs camera bytes into RGB565 pixels and reduces them to 3-bit RGB.
//   clk, reset_n  : pixel clock, synchronous active-low reset
//   i_run         : pairing allowed; low clears any half-assembled pixel
//   href, din     : camera line-valid and data byte
//   pix_valid_c   : combinational, high on the cycle the second byte is present
//   pix_rgb_c     : combinational 3-bit pixel, valid with pix_valid_c
module rgb565_pack
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_run,
    input  logic       href,
    input  logic [7:0] din,
    output logic       pix_valid_c,
    output logic [2:0] pix_rgb_c
);

    logic       r_phase;
    logic [1:0] r_hi_rg;     // red and green MSBs taken from the high byte
    logic       w_unused_din;

    // Byte phase tracker; href low drops any dangling first byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase <= 1'b0;
            r_hi_rg <= 2'b00;
        end else if (!i_run || !href) begin
            r_phase <= 1'b0;
        end else if (!r_phase) begin
            r_hi_rg <= {din[7], din[2]};
            r_phase <= 1'b1;
        end else begin
            r_phase <= 1'b0;
        end
    end

    assign pix_valid_c  = i_run & href & r_phase;
    assign pix_rgb_c    = rgb3_from_msbs(r_hi_rg[1], r_hi_rg[0], din[4]);
    assign w_unused_din = ^{din[6:5], din[3], din[1:0]};

endmodule

// File: rtl/camera_capture.sv
// Write side of the camera-to-VGA path: captures whole frames into a linear
// frame buffer, with optional 2:1 decimation in both axes.
//   clk, reset_n        : pixel clock, synchronous active-low reset
//   enable              : capture permitted, sampled at frame start
//   vsync, href, din    : camera frame sync, line valid, data byte
//   wr_en/wr_addr/wr_data : frame buffer write port (latency 1 from second byte)
//   frame_done          : one-cycle pulse at the end of a captured frame
//   busy                : high while capturing
module camera_capture
    import cam_pkg::*;
#(
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned DECIMATE = 1,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned ROW_PIX = H_RES / DECIMATE;

    cam_state_t        r_state;
    logic              r_vsync_d;
    logic              r_href_d;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_row_base;

    logic              w_vs_rise;
    logic              w_vs_fall;
    logic              w_href_fall;
    logic              w_run;
    logic              w_pix_valid;
    logic [2:0]        w_pix_rgb;
    logic              w_x_keep;
    logic              w_y_keep;
    logic [ADDR_W-1:0] w_next_base;

    assign w_vs_rise   = vsync & ~r_vsync_d;
    assign w_vs_fall   = ~vsync & r_vsync_d;
    assign w_href_fall = ~href & r_href_d;
    // A vsync rise discards the pixel being assembled on that cycle.
    assign w_run       = (r_state == S_CAPTURE) && !w_vs_rise;
    assign w_x_keep    = (r_x < X_W'(H_RES)) && ((DECIMATE == 1) || !r_x[0]);
    assign w_y_keep    = (r_y < Y_W'(V_RES)) && ((DECIMATE == 1) || !r_y[0]);
    assign w_next_base = r_row_base + ADDR_W'(ROW_PIX);

    rgb565_pack u_pack (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_run       (w_run),
        .href        (href),
        .din         (din),
        .pix_valid_c (w_pix_valid),
        .pix_rgb_c   (w_pix_rgb)
    );

    // Frame FSM, pixel/line counters and write address generation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_WAIT_VS;
            r_vsync_d  <= 1'b0;
            r_href_d   <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= BLACK;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_vsync_d  <= vsync;
            r_href_d   <= href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_WAIT_VS: begin
                    if (vsync) r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (w_vs_fall && enable) begin
                        r_state    <= S_CAPTURE;
                        busy       <= 1'b1;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_addr     <= '0;
                        r_row_base <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_vs_rise) begin
                        r_state    <= S_WAIT_START;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        if (w_pix_valid) begin
                            if (w_x_keep && w_y_keep) begin
                                wr_en   <= 1'b1;
                                wr_addr <= r_addr;
                                wr_data <= w_pix_rgb;
                                r_addr  <= r_addr + ADDR_W'(1);
                            end
                            if (r_x != '1) r_x <= r_x + X_W'(1);
                        end
                        if (w_href_fall) begin
                            r_x <= '0;
                            if (r_y != '1) r_y <= r_y + Y_W'(1);
                            // Realign to the next row start so short lines never shift later rows.
                            if (w_y_keep) begin
                                r_row_base <= w_next_base;
                                r_addr     <= w_next_base;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_WAIT_VS;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench: instance A (DECIMATE=1, 8x4) and instance B (DECIMATE=2, 8x4)
// share all camera inputs.
module tb_camera_capture;
    import cam_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] din = 8'h00;

    logic       a_wr_en, a_fd, a_busy;
    logic [4:0] a_wr_addr;
    logic [2:0] a_wr_data;
    logic       b_wr_en, b_fd, b_busy;
    logic [2:0] b_wr_addr;
    logic [2:0] b_wr_data;

    int checks = 0;
    int failures = 0;

    logic [4:0] qa_addr[$];
    logic [2:0] qa_data[$];
    logic [2:0] qb_addr[$];
    logic [2:0] qb_data[$];
    int fd_a_cnt = 0;
    int fd_b_cnt = 0;

    always #5 clk = ~clk;

    camera_capture #(.H_RES(8), .V_RES(4), .DECIMATE(1), .ADDR_W(5)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .vsync(vsync), .href(href), .din(din),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .frame_done(a_fd), .busy(a_busy)
    );

    camera_capture #(.H_RES(8), .V_RES(4), .DECIMATE(2), .ADDR_W(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .vsync(vsync), .href(href), .din(din),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .frame_done(b_fd), .busy(b_busy)
    );

    // Write and frame_done recorder; outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (a_wr_en) begin qa_addr.push_back(a_wr_addr); qa_data.push_back(a_wr_data); end
        if (b_wr_en) begin qb_addr.push_back(b_wr_addr); qb_data.push_back(b_wr_data); end
        if (a_fd) fd_a_cnt++;
        if (b_fd) fd_b_cnt++;
    end

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        @(negedge clk);
        vsync = v;
        href  = h;
        din   = d;
    endtask

    task automatic clear_logs();
        #2;
        qa_addr.delete(); qa_data.delete();
        qb_addr.delete(); qb_data.delete();
    endtask

    task automatic frame_start();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic line_bytes(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, d);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'(i % 3 == 0), 1'b1, 8'(i * 37));
            checks++;
            if ({a_wr_en, a_wr_addr, a_fd, a_busy, b_wr_en, b_wr_addr, b_fd, b_busy} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got a:en=%b addr=%0d fd=%b busy=%b b:en=%b addr=%0d fd=%b busy=%b expected all 0",
                         i, a_wr_en, a_wr_addr, a_fd, a_busy, b_wr_en, b_wr_addr, b_fd, b_busy);
            end
        end
    endtask

    task automatic test_midframe_start();
        step(1'b0, 1'b1, 8'hFF);
        reset_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (qa_addr.size() != 0 || qb_addr.size() != 0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL midframe_no_write got writes a=%0d b=%0d busy=%b expected 0 0 0",
                     qa_addr.size(), qb_addr.size(), a_busy);
        end
        frame_start();
        checks++;
        if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy got a=%b b=%b expected 1 1", a_busy, b_busy);
        end
    endtask

    task automatic test_colour();
        logic [7:0] bytes[8];
        logic [2:0] exp_rgb[4];
        int fd0;
        bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
        exp_rgb = '{RED, 3'b010, 3'b001, WHITE};
        clear_logs();
        fd0 = fd_a_cnt;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) step(1'b0, 1'b1, bytes[i]);
            else       step(1'b0, 1'b0, 8'h00);
            if (i > 0) begin
                checks++;
                if ((i - 1) % 2 == 0) begin
                    if (a_wr_en !== 1'b0) begin
                        failures++;
                        $display("FAIL colour_no_write byte=%0d got wr_en=%b expected 0", i - 1, a_wr_en);
                    end
                end else if (a_wr_en !== 1'b1 || a_wr_addr !== 5'((i - 1) / 2) || a_wr_data !== exp_rgb[(i - 1) / 2]) begin
                    failures++;
                    $display("FAIL colour_write byte=%0d got en=%b addr=%0d data=%b expected en=1 addr=%0d data=%b",
                             i - 1, a_wr_en, a_wr_addr, a_wr_data, (i - 1) / 2, exp_rgb[(i - 1) / 2]);
                end
            end
        end
        step(1'b0, 1'b0, 8'h00);
        frame_end();
        checks++;
        if (qa_addr.size() != 4 || fd_a_cnt - fd0 != 1) begin
            failures++;
            $display("FAIL colour_frame got writes=%0d frame_done=%0d expected 4 1", qa_addr.size(), fd_a_cnt - fd0);
        end
    endtask

    task automatic test_full_frame();
        int fa0, fb0;
        clear_logs();
        fa0 = fd_a_cnt;
        fb0 = fd_b_cnt;
        frame_start();
        for (int l = 0; l < 4; l++) line_bytes(16, 8'hFF);
        frame_end();
        checks++;
        if (qb_addr.size() != 8) begin
            failures++;
            $display("FAIL full_frame_b_count got %0d expected 8", qb_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (qb_addr[i] !== 3'(i) || qb_data[i] !== WHITE) begin
                    failures++;
                    $display("FAIL full_frame_b_write idx=%0d got addr=%0d data=%b expected addr=%0d data=111",
                             i, qb_addr[i], qb_data[i], i);
                end
            end
        end
        checks++;
        if (qa_addr.size() != 32 || qa_addr[qa_addr.size() - 1] !== 5'd31) begin
            failures++;
            $display("FAIL full_frame_a got count=%0d expected 32 ending at 31", qa_addr.size());
        end
        checks++;
        if (fd_a_cnt - fa0 != 1 || fd_b_cnt - fb0 != 1) begin
            failures++;
            $display("FAIL full_frame_done got a=%0d b=%0d expected 1 1", fd_a_cnt - fa0, fd_b_cnt - fb0);
        end
    endtask

    task automatic test_boundaries();
        logic [4:0] exp_addr[14];
        exp_addr = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
        clear_logs();
        frame_start();
        line_bytes(9, 8'hFF);
        line_bytes(20, 8'hFF);
        line_bytes(4, 8'hFF);
        frame_end();
        checks++;
        if (qa_addr.size() != 14) begin
            failures++;
            $display("FAIL boundary_count got %0d expected 14", qa_addr.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                checks++;
                if (qa_addr[i] !== exp_addr[i]) begin
                    failures++;
                    $display("FAIL boundary_addr idx=%0d got %0d expected %0d", i, qa_addr[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_races();
        int fa0;
        clear_logs();
        frame_start();
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (a_wr_en !== 1'b0 || a_fd !== 1'b1 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL race_vsync got wr_en=%b frame_done=%b busy=%b expected 0 1 0", a_wr_en, a_fd, a_busy);
        end
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (qa_addr.size() != 1 || a_fd !== 1'b0) begin
            failures++;
            $display("FAIL race_vsync_writes got writes=%0d frame_done=%b expected 1 0", qa_addr.size(), a_fd);
        end

        // Reset mid-line, then require a full vsync high-to-low before capturing.
        frame_start();
        clear_logs();
        fa0 = fd_a_cnt;
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        reset_n = 1'b0;
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (fd_a_cnt != fa0 || a_busy !== 1'b0 || qa_addr.size() != 1) begin
            failures++;
            $display("FAIL reset_midline got frame_done=%0d busy=%b writes=%0d expected 0 0 1",
                     fd_a_cnt - fa0, a_busy, qa_addr.size());
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        line_bytes(4, 8'hFF);
        checks++;
        if (qa_addr.size() != 3) begin
            failures++;
            $display("FAIL restart_count got %0d expected 3", qa_addr.size());
        end else if (qa_addr[1] !== 5'd0 || qa_data[1] !== WHITE || qa_addr[2] !== 5'd1) begin
            failures++;
            $display("FAIL restart_addr got %0d/%b %0d expected 0/111 1", qa_addr[1], qa_data[1], qa_addr[2]);
        end
    endtask

    initial begin
        test_reset();
        test_midframe_start();
        test_colour();
        test_full_frame();
        test_boundaries();
        test_races();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
